// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared-ALU port and the response channel of alu_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface alu_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned CTRL_WIDTH = 3;

    // Requester 0: main execute path
    logic                  r0_valid;
    logic                  r0_ready;
    logic [DATA_WIDTH-1:0] r0_op1;
    logic [DATA_WIDTH-1:0] r0_op2;
    logic [DATA_WIDTH-1:0] r0_imm;
    logic                  r0_src;
    logic [CTRL_WIDTH-1:0] r0_ctrl;

    // Requester 1: address/branch helper
    logic                  r1_valid;
    logic                  r1_ready;
    logic [DATA_WIDTH-1:0] r1_op1;
    logic [DATA_WIDTH-1:0] r1_op2;
    logic [DATA_WIDTH-1:0] r1_imm;
    logic                  r1_src;
    logic [CTRL_WIDTH-1:0] r1_ctrl;

    // Shared ALU
    logic [DATA_WIDTH-1:0] alu_op1;
    logic [DATA_WIDTH-1:0] alu_reg_op2;
    logic [DATA_WIDTH-1:0] alu_imm;
    logic                  alu_src;
    logic [CTRL_WIDTH-1:0] alu_ctrl;
    logic [DATA_WIDTH-1:0] alu_out;
    logic                  alu_eq;

    // Response channel
    logic                  rsp_valid;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_eq;
    logic                  rsp_ready;

    modport slave (
        input  r0_valid, r0_op1, r0_op2, r0_imm, r0_src, r0_ctrl,
        output r0_ready,
        input  r1_valid, r1_op1, r1_op2, r1_imm, r1_src, r1_ctrl,
        output r1_ready,
        output alu_op1, alu_reg_op2, alu_imm, alu_src, alu_ctrl,
        input  alu_out, alu_eq,
        output rsp_valid, rsp_id, rsp_data, rsp_eq,
        input  rsp_ready
    );

    modport master (
        output r0_valid, r0_op1, r0_op2, r0_imm, r0_src, r0_ctrl,
        input  r0_ready,
        output r1_valid, r1_op1, r1_op2, r1_imm, r1_src, r1_ctrl,
        input  r1_ready,
        input  alu_op1, alu_reg_op2, alu_imm, alu_src, alu_ctrl,
        output alu_out, alu_eq,
        input  rsp_valid, rsp_id, rsp_data, rsp_eq,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one single-cycle ALU between two requesters: accept, drive ALU for one cycle, return tagged result.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    localparam int unsigned CTRL_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] op2;
        logic [DATA_WIDTH-1:0] imm;
        logic                  src;
        logic [CTRL_WIDTH-1:0] ctrl;
        logic                  id;
    } op_t;

    state_t                state_q, state_d;
    op_t                   op_q, op_d;
    logic                  last_q, last_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_eq_q, rsp_eq_d;
    logic                  gnt0_c, gnt1_c;

    // Grant is only offered while idle and only to a requester that is currently valid
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.r0_valid && bus.r1_valid) begin
`ifdef ALU_ARB_RR_EN
                gnt0_c = last_q;
                gnt1_c = ~last_q;
`else
                gnt0_c = 1'b1;
`endif
            end else begin
                gnt0_c = bus.r0_valid;
                gnt1_c = bus.r1_valid;
            end
        end
    end

    // Next-state and register updates
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_eq_d    = rsp_eq_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt1_c) begin
                    op_d.op1  = bus.r1_op1;
                    op_d.op2  = bus.r1_op2;
                    op_d.imm  = bus.r1_imm;
                    op_d.src  = bus.r1_src;
                    op_d.ctrl = bus.r1_ctrl;
                    op_d.id   = 1'b1;
                    last_d    = 1'b1;
                    state_d   = ST_EXEC;
                end else if (gnt0_c) begin
                    op_d.op1  = bus.r0_op1;
                    op_d.op2  = bus.r0_op2;
                    op_d.imm  = bus.r0_imm;
                    op_d.src  = bus.r0_src;
                    op_d.ctrl = bus.r0_ctrl;
                    op_d.id   = 1'b0;
                    last_d    = 1'b0;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = bus.alu_out;
                rsp_eq_d    = bus.alu_eq;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset also discards any in-flight operation; pointer starts at 1 so requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_eq_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_eq_q    <= rsp_eq_d;
        end
    end

    assign bus.r0_ready    = gnt0_c;
    assign bus.r1_ready    = gnt1_c;

    // ALU inputs hold the operand registers in every state
    assign bus.alu_op1     = op_q.op1;
    assign bus.alu_reg_op2 = op_q.op2;
    assign bus.alu_imm     = op_q.imm;
    assign bus.alu_src     = op_q.src;
    assign bus.alu_ctrl    = op_q.ctrl;

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = op_q.id;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_eq      = rsp_eq_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: transaction-level model predicts grants/responses, monitor checks them.
// Honours ALU_ARB_RR_EN the same way the design does.
module tb_alu_arbiter;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [DW-1:0] imm;
        logic          src;
        logic [2:0]    ctrl;
    } req_t;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
        logic          eq;
    } rsp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic m_busy = 1'b0;
    logic m_last = 1'b1;
    int   m_acc_cyc = 0;
    req_t m_alu = '0;
    rsp_t exp_q[$];
    int   obs_log[$];
    logic          last_rsp_id = 1'b0;
    logic [DW-1:0] last_rsp_data = '0;
    logic          last_rsp_eq = 1'b0;
    logic [DW-1:0] alu_b;

    // Behaviour of the shared ALU sitting outside the arbiter
    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [2:0] c);
        logic [$clog2(DW)-1:0] sh;
        sh = b[$clog2(DW)-1:0];
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
            3'd6:    return a << sh;
            default: return a >> sh;
        endcase
    endfunction

    always_comb begin
        alu_b       = bus.alu_src ? bus.alu_imm : bus.alu_reg_op2;
        bus.alu_out = alu_fn(bus.alu_op1, alu_b, bus.alu_ctrl);
        bus.alu_eq  = (bus.alu_op1 == alu_b);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.op1  = $urandom;
        r.op2  = ($urandom_range(0, 3) == 0) ? r.op1 : $urandom;
        r.imm  = ($urandom_range(0, 3) == 0) ? r.op1 : $urandom;
        r.src  = 1'($urandom_range(0, 1));
        r.ctrl = 3'($urandom_range(0, 7));
        return r;
    endfunction

    task automatic set_req(input int id, input logic v, input req_t r);
        if (id == 0) begin
            bus.r0_valid = v; bus.r0_op1 = r.op1; bus.r0_op2 = r.op2;
            bus.r0_imm = r.imm; bus.r0_src = r.src; bus.r0_ctrl = r.ctrl;
        end else begin
            bus.r1_valid = v; bus.r1_op1 = r.op1; bus.r1_op2 = r.op2;
            bus.r1_imm = r.imm; bus.r1_src = r.src; bus.r1_ctrl = r.ctrl;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: one op at a time, response valid two cycles after acceptance, free after rsp handshake
    always begin : predictor
        int   prefer;
        int   winner;
        logic exp_rv;
        req_t r;
        rsp_t e;
        @(negedge clk);
        #2;
        exp_rv = m_busy && (cyc >= m_acc_cyc + 2);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
        chk("alu_op1", 64'(bus.alu_op1), 64'(m_alu.op1));
        chk("alu_reg_op2", 64'(bus.alu_reg_op2), 64'(m_alu.op2));
        chk("alu_imm", 64'(bus.alu_imm), 64'(m_alu.imm));
        chk("alu_src", 64'(bus.alu_src), 64'(m_alu.src));
        chk("alu_ctrl", 64'(bus.alu_ctrl), 64'(m_alu.ctrl));
`ifdef ALU_ARB_RR_EN
        prefer = m_last ? 0 : 1;
`else
        prefer = 0;
`endif
        winner = -1;
        if (!m_busy) begin
            if (bus.r0_valid && bus.r1_valid) winner = prefer;
            else if (bus.r0_valid)            winner = 0;
            else if (bus.r1_valid)            winner = 1;
        end
        chk("r0_ready", 64'(bus.r0_ready), 64'(winner == 0));
        chk("r1_ready", 64'(bus.r1_ready), 64'(winner == 1));
        if (bus.r0_valid === 1'b1 && bus.r0_ready === 1'b1)      obs_log.push_back(0);
        else if (bus.r1_valid === 1'b1 && bus.r1_ready === 1'b1) obs_log.push_back(1);
        if (winner >= 0) begin
            if (winner == 0) r = '{bus.r0_op1, bus.r0_op2, bus.r0_imm, bus.r0_src, bus.r0_ctrl};
            else             r = '{bus.r1_op1, bus.r1_op2, bus.r1_imm, bus.r1_src, bus.r1_ctrl};
            e.id   = (winner == 1);
            e.data = alu_fn(r.op1, r.src ? r.imm : r.op2, r.ctrl);
            e.eq   = (r.op1 == (r.src ? r.imm : r.op2));
            exp_q.push_back(e);
            m_alu     = r;
            m_last    = (winner == 1);
            m_busy    = 1'b1;
            m_acc_cyc = cyc;
        end else if (exp_rv && bus.rsp_ready) begin
            m_busy = 1'b0;
        end
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            m_alu  = '0;
            exp_q.delete();
        end
    end

    // Response monitor: every cycle a response is presented it must match the head of the scoreboard
    always begin : monitor
        rsp_t e;
        @(negedge clk);
        #2;
        if (bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                fail_now("rsp_unexpected: response with nothing outstanding");
            end else begin
                e = exp_q[0];
                chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                chk("rsp_eq", 64'(bus.rsp_eq), 64'(e.eq));
                if (bus.rsp_ready) begin
                    last_rsp_id   = bus.rsp_id;
                    last_rsp_data = bus.rsp_data;
                    last_rsp_eq   = bus.rsp_eq;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input int id, input req_t r);
        bit done;
        done = 1'b0;
        @(negedge clk);
        set_req(id, 1'b1, r);
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (((id == 0) ? bus.r0_ready : bus.r1_ready) === 1'b1) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) fail_now("issue_timeout");
        @(negedge clk);
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #3;
            if (!m_busy && exp_q.size() == 0 && bus.rsp_valid !== 1'b1) done = 1'b1;
        end
        if (!done) fail_now("idle_timeout");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        req_t r;
        int   base;
        bit   seen;
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rsp_data", 64'(bus.rsp_data), 64'(0));
        chk("reset_rsp_id", 64'(bus.rsp_id), 64'(0));
        chk("reset_rsp_eq", 64'(bus.rsp_eq), 64'(0));
        rst = 1'b0;
        bus.rsp_ready = 1'b1;

        // Single add from requester 0
        r = '{32'd5, 32'd7, 32'd0, 1'b0, 3'd0};
        issue(0, r);
        wait_idle();
        chk("add_rsp_data", 64'(last_rsp_data), 64'(12));
        chk("add_rsp_id", 64'(last_rsp_id), 64'(0));
        chk("add_rsp_eq", 64'(last_rsp_eq), 64'(0));

        // Immediate operand from requester 1
        r = '{32'h10, 32'h99, 32'h10, 1'b1, 3'd0};
        issue(1, r);
        wait_idle();
        chk("imm_rsp_data", 64'(last_rsp_data), 64'(32'h20));
        chk("imm_rsp_id", 64'(last_rsp_id), 64'(1));
        chk("imm_rsp_eq", 64'(last_rsp_eq), 64'(1));

        // Contention: both valids held through four operations
        @(negedge clk);
        base = obs_log.size();
        set_req(0, 1'b1, rand_req());
        set_req(1, 1'b1, rand_req());
        for (int i = 0; i < 60 && obs_log.size() < base + 4; i++) begin
            @(negedge clk);
            if (obs_log.size() < base + 4) begin
                set_req(0, 1'b1, rand_req());
                set_req(1, 1'b1, rand_req());
            end
        end
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        if (obs_log.size() < base + 4) begin
            fail_now("contention_timeout");
        end else begin
            for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
                chk("contention_grant", 64'(obs_log[base + k]), 64'(k % 2));
`else
                chk("contention_grant", 64'(obs_log[base + k]), 64'(0));
`endif
            end
        end
        wait_idle();

        // Back-pressure: hold the response five cycles while both requesters wait
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        issue(0, rand_req());
        set_req(0, 1'b1, rand_req());
        set_req(1, 1'b1, rand_req());
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) fail_now("bp_rsp_timeout");
        repeat (5) @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #2;
        chk("bp_rsp_valid_fell", 64'(bus.rsp_valid), 64'(0));
        chk("bp_new_accept", 64'(bus.r0_ready | bus.r1_ready), 64'(1));
        @(negedge clk);
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        wait_idle();

        // Reset while the ALU is evaluating
        r = '{32'hDEAD_0001, 32'hBEEF_0002, 32'hCAFE_0003, 1'b1, 3'd4};
        issue(0, r);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("midrst_alu_op1", 64'(bus.alu_op1), 64'(0));
        chk("midrst_alu_reg_op2", 64'(bus.alu_reg_op2), 64'(0));
        chk("midrst_alu_imm", 64'(bus.alu_imm), 64'(0));
        chk("midrst_alu_src", 64'(bus.alu_src), 64'(0));
        repeat (6) @(negedge clk);
        set_req(0, 1'b1, rand_req());
        set_req(1, 1'b1, rand_req());
        #1;
        chk("midrst_contention_r0", 64'(bus.r0_ready), 64'(1));
        chk("midrst_contention_r1", 64'(bus.r1_ready), 64'(0));
        @(negedge clk);
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        wait_idle();

        // Randomised traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            set_req(0, 1'($urandom_range(0, 2) != 0), rand_req());
            set_req(1, 1'($urandom_range(0, 2) != 0), rand_req());
            bus.rsp_ready = 1'($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
